ksz_bus_arbiter: RTL and testbench
==================================

// Module: ksz_bus_arbiter
// PURPOSE
//  Shares the single KSZ8851 register-IO engine (8-bit offset, length, WR, 16-bit write data,
//  NewCommand, Dummy_Write; 4-bit state feedback) among NREQ requesters (init, receive, transmit).
//  Grants ownership per transaction (a multi-command register sequence), round-robin. Hands off
//  only when the engine is idle, and reclaims the bus from a stalled owner via a watchdog.
// PARAMETERS
//  NREQ     3     number of requesters (2..4); index 0 = init, 1 = receive, 2 = transmit
//  TIMEOUT  4095  idle-owner watchdog limit in sysclk cycles (12-bit counter)
// PORTS
//  sysclk        in   1        system clock
//  reset         in   1        asynchronous, active-low
//  req           in   NREQ     requester i holds high for its entire transaction
//  grant         out  NREQ     one-hot ownership, registered
//  owner         out  2        index of granted requester (valid when busy=1)
//  busy          out  1        1 while any grant is active
//  timeout_err   out  1        one-cycle pulse when the watchdog revokes a grant
//  offset_i      in   8*NREQ   per-requester register offset, requester i at [8i+7:8i]
//  length_i      in   NREQ     per-requester length
//  wr_i          in   NREQ     per-requester WR
//  wdata_i       in   16*NREQ  per-requester write data
//  newcmd_i      in   NREQ     per-requester NewCommand
//  dummy_i       in   NREQ     per-requester Dummy_Write
//  offset        out  8        to engine: muxed from owner
//  length        out  1        to engine: muxed from owner
//  WR            out  1        to engine: muxed from owner
//  writeData     out  16       to engine: muxed from owner
//  NewCommand    out  1        to engine: muxed from owner
//  Dummy_Write   out  1        to engine: muxed from owner
//  state         in   4        engine state; Wait = 4'b1001 means engine idle
//  rdata_valid   out  NREQ     =grant; readData fans out unmuxed, qualified by grant
// BEHAVIOUR
//  Reset: grant=0, owner=0, busy=0, timeout_err=0, FSM=IDLE, rr_ptr=NREQ-1, wdog=0, mask=0.
//  Output mux: combinational from registered grant. No grant -> offset=0, length=0, WR=0,
//   writeData=0, NewCommand=0, Dummy_Write=0. Owner tristate values pass through unchanged.
//  FSM states:
//   IDLE  - If any (req & ~mask) and state==Wait: pick the first requester searching
//           rr_ptr+1, rr_ptr+2, ... (mod NREQ). Next cycle: grant, owner, busy set;
//           rr_ptr<=winner; go to GRANT. 1-cycle latency from req to grant.
//   GRANT - Owner drops req -> DRAIN. Watchdog trips -> DRAIN, timeout_err=1 for 1 cycle,
//           mask[owner]<=1.
//   DRAIN - grant held, NewCommand forced 0. Wait for state==Wait, then clear grant/busy and
//           go to IDLE. Always at least 1 cycle in IDLE between owners.
//  Watchdog: in GRANT, wdog++ each cycle with state==Wait and owner newcmd_i==0. Cleared on any
//   other cycle and on entry to GRANT. Trip when wdog==TIMEOUT. Saturates, never wraps.
//  mask[i] clears when req[i] is low. A masked requester is not granted until it cycles req.
//  Simultaneous requests in IDLE: round-robin only; a requester just served is never re-granted
//   while another unmasked requester is asserting.
//  Owner drops req and asserts newcmd in the same cycle: newcmd is ignored; DRAIN masks it.
//  req rising while engine is not in Wait: grant is deferred until state==Wait.
//  Asynchronous reset mid-transaction: all outputs return to reset values at once. The engine
//   is left to finish on its own.
// TESTING
//  T1 req=3'b001, state=Wait -> grant=001 1 cycle later; offset/WR follow requester 0; drop
//     req -> grant=000 after state==Wait.
//  T2 req=3'b111 held, each owner drops after 1 command -> grant order 001,010,100,001.
//  T3 req[2] high with newcmd_i[2]=0 for 4095 Wait cycles -> timeout_err pulse, grant=000,
//     req[2] not re-granted until it toggles low then high.
//  T4 req[1] drops while state=Write1 -> grant held until state=Wait, NewCommand=0 throughout.
//  T5 reset low during GRANT with NewCommand=1 -> next edge: grant=0, NewCommand=0, busy=0;
//     after release, req=3'b001 is granted first.
//  T6 req[0] and req[2] rise together with rr_ptr=0 -> requester 2 granted first.

Source files
------------

// File: rtl/ksz_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ksz_bus_arbiter_if
// Bundles every signal between the requesters, the KSZ8851 register-IO engine
// and the bus arbiter.
//
// Handshake (request/hold): requester i raises req[i] and keeps it high for
// its whole multi-command transaction. grant[i] (registered, one-hot) tells it
// it owns the engine. Its command fields (offset_i/length_i/wr_i/wdata_i/
// newcmd_i/dummy_i) reach the engine only while it is granted. Dropping
// req[i] ends the transaction, and the grant is withdrawn once the engine
// reports its idle state (Wait). There is no ready/valid back-pressure on
// req: the grant itself is the acceptance.
//
// Modports
//   slave  : the arbiter (consumes req/command fields/state, drives grant/mux)
//   master : the requester + engine side (drives req/command fields/state)
// ---------------------------------------------------------------------------
interface ksz_bus_arbiter_if #(
   parameter int NREQ = 3
);
   // requester handshake
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    grant;
   logic [1:0]         owner;
   logic               busy;
   logic               timeout_err;

   // per-requester command fields, requester i in slice i
   logic [8*NREQ-1:0]  offset_i;
   logic [NREQ-1:0]    length_i;
   logic [NREQ-1:0]    wr_i;
   logic [16*NREQ-1:0] wdata_i;
   logic [NREQ-1:0]    newcmd_i;
   logic [NREQ-1:0]    dummy_i;

   // muxed command to the engine
   logic [7:0]         offset;
   logic               length;
   logic               WR;
   logic [15:0]        writeData;
   logic               NewCommand;
   logic               Dummy_Write;

   // engine state feedback and read-data qualifier
   logic [3:0]         state;
   logic [NREQ-1:0]    rdata_valid;

   modport slave (
      input  req, offset_i, length_i, wr_i, wdata_i, newcmd_i, dummy_i, state,
      output grant, owner, busy, timeout_err,
      output offset, length, WR, writeData, NewCommand, Dummy_Write, rdata_valid
   );

   modport master (
      output req, offset_i, length_i, wr_i, wdata_i, newcmd_i, dummy_i, state,
      input  grant, owner, busy, timeout_err,
      input  offset, length, WR, writeData, NewCommand, Dummy_Write, rdata_valid
   );
endinterface

// File: rtl/ksz_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ksz_bus_arbiter
// Shares one KSZ8851 register-IO engine among NREQ requesters (0 = init,
// 1 = receive, 2 = transmit). Ownership is granted per transaction in
// round-robin order, handed over only while the engine sits in Wait, and a
// watchdog reclaims the engine from an owner that keeps it idle too long.
//
// Ports
//   sysclk     : system clock
//   reset      : asynchronous, active-low
//   bus        : ksz_bus_arbiter_if.slave (requests, command mux, state)
//   dbg_state  : current FSM state (0 IDLE, 1 GRANT, 2 DRAIN)
// ---------------------------------------------------------------------------
module ksz_bus_arbiter #(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 4095
) (
   input  logic                    sysclk,
   input  logic                    reset,
   ksz_bus_arbiter_if.slave        bus,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DRAIN = 2'd2
   } fsm_t;

   localparam logic [3:0]  ST_WAIT    = 4'b1001;
   localparam logic [11:0] WDOG_LIMIT = 12'(TIMEOUT);
   localparam logic [1:0]  RR_RESET   = 2'(NREQ - 1);

   fsm_t            fsm_q, fsm_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [1:0]      owner_q, owner_d;
   logic            busy_q, busy_d;
   logic            tout_q, tout_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [11:0]     wdog_q, wdog_d;
   logic [NREQ-1:0] mask_q, mask_d;

   logic            engine_idle;
   logic            owner_req;
   logic            owner_newcmd;
   logic [NREQ-1:0] eligible;
   logic            pick_found;
   logic [1:0]      pick_idx;
   logic [2:0]      cand;

   assign engine_idle  = (bus.state == ST_WAIT);
   assign owner_req    = bus.req[owner_q];
   assign owner_newcmd = bus.newcmd_i[owner_q];
   assign eligible     = bus.req & ~mask_q;

   // Round-robin search starting just after the last winner, so the
   // requester served most recently is always considered last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + 3'(k);
         if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
         if (!pick_found && eligible[cand[1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[1:0];
         end
      end
   end

   // Next-state logic
   always_comb begin
      fsm_d    = fsm_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      busy_d   = busy_q;
      tout_d   = 1'b0;
      rr_ptr_d = rr_ptr_q;
      wdog_d   = wdog_q;
      // A mask bit survives only while its requester keeps req high.
      mask_d   = mask_q & bus.req;

      case (fsm_q)
         S_IDLE: begin
            wdog_d = '0;
            if (pick_found && engine_idle) begin
               grant_d  = NREQ'(1) << pick_idx;
               owner_d  = pick_idx;
               busy_d   = 1'b1;
               rr_ptr_d = pick_idx;
               fsm_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!owner_req) begin
               fsm_d  = S_DRAIN;
               wdog_d = '0;
            end else if (wdog_q == WDOG_LIMIT) begin
               fsm_d  = S_DRAIN;
               tout_d = 1'b1;
               wdog_d = '0;
               mask_d = mask_d | (NREQ'(1) << owner_q);
            end else if (engine_idle && !owner_newcmd) begin
               if (wdog_q != 12'hFFF) wdog_d = wdog_q + 12'd1;
            end else begin
               wdog_d = '0;
            end
         end
         S_DRAIN: begin
            wdog_d = '0;
            if (engine_idle) begin
               grant_d = '0;
               busy_d  = 1'b0;
               fsm_d   = S_IDLE;
            end
         end
         default: begin
            fsm_d   = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            wdog_d  = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         fsm_q    <= S_IDLE;
         grant_q  <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         tout_q   <= 1'b0;
         rr_ptr_q <= RR_RESET;
         wdog_q   <= '0;
         mask_q   <= '0;
      end else begin
         fsm_q    <= fsm_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         tout_q   <= tout_d;
         rr_ptr_q <= rr_ptr_d;
         wdog_q   <= wdog_d;
         mask_q   <= mask_d;
      end
   end

   // Command mux, driven only from registered ownership. NewCommand is
   // suppressed in DRAIN and in the cycle the owner lets go of req, so a
   // command raised together with the release never reaches the engine.
   always_comb begin
      bus.offset      = '0;
      bus.length      = 1'b0;
      bus.WR          = 1'b0;
      bus.writeData   = '0;
      bus.NewCommand  = 1'b0;
      bus.Dummy_Write = 1'b0;
      if (|grant_q) begin
         bus.offset      = bus.offset_i[int'(owner_q)*8 +: 8];
         bus.length      = bus.length_i[owner_q];
         bus.WR          = bus.wr_i[owner_q];
         bus.writeData   = bus.wdata_i[int'(owner_q)*16 +: 16];
         bus.Dummy_Write = bus.dummy_i[owner_q];
         bus.NewCommand  = owner_newcmd && owner_req && (fsm_q == S_GRANT);
      end
   end

   assign bus.grant       = grant_q;
   assign bus.owner       = owner_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = tout_q;
   assign bus.rdata_valid = grant_q;
   assign dbg_state       = fsm_q;

endmodule

// File: tb/tb_ksz_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ksz_bus_arbiter
// Directed bench for ksz_bus_arbiter. The stimulus thread pushes the expected
// {timeout_err, grant} of every grant change / timeout pulse into exp_q; a
// monitor pops and compares whenever the DUT shows such an event. Cycle-exact
// mux and latency values are checked inline against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ksz_bus_arbiter;

   localparam int         NREQ   = 3;
   localparam logic [3:0] WAIT   = 4'b1001;
   localparam logic [3:0] WRITE1 = 4'b0011;

   logic       sysclk;
   logic       reset;
   logic [1:0] dbg_state;

   ksz_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   ksz_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(4095)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] exp_q[$];

   task automatic cyc(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic push(input logic tout, input logic [2:0] g);
      exp_q.push_back({tout, g});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   initial begin
      logic [2:0] prev_g;
      logic [3:0] ev;
      logic [3:0] ex;
      prev_g = '0;
      forever begin
         @(negedge sysclk);
         if (bus.grant !== prev_g || bus.timeout_err === 1'b1) begin
            ev = {bus.timeout_err, bus.grant};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: got %0h with empty expected queue", ev);
            end else begin
               ex = exp_q.pop_front();
               if (ev !== ex) begin
                  n_err++;
                  $display("FAIL sb_event: got %0h expected %0h", ev, ex);
               end
            end
            prev_g = bus.grant;
         end
      end
   end

   // stimulus
   initial begin
      int n_wd;
      logic found;

      reset        = 1'b0;
      bus.req      = '0;
      bus.state    = WAIT;
      bus.offset_i = {8'hC2, 8'hB1, 8'hA0};
      bus.length_i = 3'b010;
      bus.wr_i     = 3'b101;
      bus.wdata_i  = {16'hCC03, 16'hBB02, 16'hAA01};
      bus.newcmd_i = 3'b111;
      bus.dummy_i  = 3'b100;

      // reset state
      cyc(2);
      chk("rst_grant", bus.grant, 3'b000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_owner", bus.owner, 2'd0);
      chk("rst_tout", bus.timeout_err, 1'b0);
      chk("rst_offset", bus.offset, 8'h00);
      chk("rst_ncmd", bus.NewCommand, 1'b0);
      chk("rst_fsm", dbg_state, 2'd0);
      reset = 1'b1;
      cyc(1);

      // T1: single requester 0
      push(0, 3'b001);
      bus.req = 3'b001;
      cyc(1);
      chk("t1_grant", bus.grant, 3'b001);
      chk("t1_busy", bus.busy, 1'b1);
      chk("t1_owner", bus.owner, 2'd0);
      chk("t1_offset", bus.offset, 8'hA0);
      chk("t1_wr", bus.WR, 1'b1);
      chk("t1_wdata", bus.writeData, 16'hAA01);
      chk("t1_length", bus.length, 1'b0);
      chk("t1_ncmd", bus.NewCommand, 1'b1);
      chk("t1_rvalid", bus.rdata_valid, 3'b001);
      push(0, 3'b000);
      bus.req = 3'b000;
      cyc(1);
      chk("t1_drain_hold", bus.grant, 3'b001);
      chk("t1_drain_ncmd", bus.NewCommand, 1'b0);
      cyc(1);
      chk("t1_release", bus.grant, 3'b000);
      chk("t1_busy_off", bus.busy, 1'b0);
      chk("t1_offset_off", bus.offset, 8'h00);

      // T6: req 0 and 2 together, last winner 0 -> requester 2 first
      push(0, 3'b100);
      bus.req = 3'b101;
      cyc(1);
      chk("t6_grant", bus.grant, 3'b100);
      chk("t6_owner", bus.owner, 2'd2);
      chk("t6_offset", bus.offset, 8'hC2);
      chk("t6_wdata", bus.writeData, 16'hCC03);
      chk("t6_dummy", bus.Dummy_Write, 1'b1);
      push(0, 3'b000);
      push(0, 3'b001);
      bus.req = 3'b001;
      cyc(2);
      chk("t6_gap", bus.grant, 3'b000);
      cyc(1);
      chk("t6_second", bus.grant, 3'b001);
      push(0, 3'b000);
      bus.req = 3'b000;
      cyc(2);

      // T4: owner 1 drops req while the engine is busy
      push(0, 3'b010);
      bus.req = 3'b010;
      cyc(1);
      chk("t4_grant", bus.grant, 3'b010);
      chk("t4_offset", bus.offset, 8'hB1);
      chk("t4_length", bus.length, 1'b1);
      chk("t4_wr", bus.WR, 1'b0);
      chk("t4_ncmd_on", bus.NewCommand, 1'b1);
      bus.state = WRITE1;
      push(0, 3'b000);
      bus.req = 3'b000;
      #1;
      chk("t4_ncmd_drop", bus.NewCommand, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("t4_hold", bus.grant, 3'b010);
         chk("t4_ncmd_hold", bus.NewCommand, 1'b0);
      end
      bus.state = WAIT;
      cyc(1);
      chk("t4_release", bus.grant, 3'b000);

      // request while engine busy is deferred until Wait
      bus.state = WRITE1;
      bus.req   = 3'b001;
      cyc(3);
      chk("defer_nogrant", bus.grant, 3'b000);
      push(0, 3'b001);
      bus.state = WAIT;
      cyc(1);
      chk("defer_grant", bus.grant, 3'b001);

      // T5: asynchronous reset while owner 0 issues a command
      chk("t5_pre_ncmd", bus.NewCommand, 1'b1);
      push(0, 3'b000);
      reset = 1'b0;
      #1;
      chk("t5_grant", bus.grant, 3'b000);
      chk("t5_ncmd", bus.NewCommand, 1'b0);
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_fsm", dbg_state, 2'd0);
      cyc(1);
      push(0, 3'b001);
      bus.req = 3'b011;
      reset   = 1'b1;
      cyc(1);
      chk("t5_first", bus.grant, 3'b001);
      push(0, 3'b000);
      push(0, 3'b010);
      bus.req = 3'b010;
      cyc(3);
      chk("t5_next", bus.grant, 3'b010);
      push(0, 3'b000);
      bus.req = 3'b000;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      cyc(1);

      // T2: all three requesting, round-robin 0,1,2,0
      push(0, 3'b001);
      bus.req = 3'b111;
      cyc(1);
      chk("t2_g0", bus.grant, 3'b001);
      push(0, 3'b000);
      push(0, 3'b010);
      bus.req = 3'b110;
      cyc(2);
      chk("t2_gap", bus.grant, 3'b000);
      bus.req = 3'b111;
      cyc(1);
      chk("t2_g1", bus.grant, 3'b010);
      push(0, 3'b000);
      push(0, 3'b100);
      bus.req = 3'b101;
      cyc(3);
      chk("t2_g2", bus.grant, 3'b100);
      push(0, 3'b000);
      push(0, 3'b001);
      bus.req = 3'b001;
      cyc(3);
      chk("t2_g0_again", bus.grant, 3'b001);
      push(0, 3'b000);
      bus.req = 3'b000;
      cyc(2);

      // T3: stalled owner 2 is reclaimed by the watchdog
      bus.newcmd_i = 3'b011;
      push(0, 3'b100);
      bus.req = 3'b100;
      cyc(1);
      chk("t3_grant", bus.grant, 3'b100);
      push(1, 3'b100);
      push(0, 3'b000);
      n_wd  = 0;
      found = 1'b0;
      for (int i = 1; i <= 5000 && !found; i++) begin
         cyc(1);
         if (bus.timeout_err === 1'b1) begin
            found = 1'b1;
            n_wd  = i;
         end
      end
      chk("t3_wdog_cycles", n_wd, 4096);
      chk("t3_grant_at_trip", bus.grant, 3'b100);
      cyc(1);
      chk("t3_revoked", bus.grant, 3'b000);
      chk("t3_pulse_end", bus.timeout_err, 1'b0);
      cyc(5);
      chk("t3_masked", bus.grant, 3'b000);
      push(0, 3'b100);
      bus.req = 3'b000;
      cyc(1);
      bus.req      = 3'b100;
      bus.newcmd_i = 3'b111;
      cyc(1);
      chk("t3_regrant", bus.grant, 3'b100);
      push(0, 3'b000);
      bus.req = 3'b000;
      cyc(3);

      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
